multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the multicycle MIPS datapath. Instructions share one memory, one ALU and one register file over several cycles.
- Decodes opcode/func, drives the datapath mux selects and write enables per state, and waits on a memory-ready handshake.
- Sits beside the datapath in place of the single-cycle controller and reuses the same ALUop/func-to-ALU_control mapping internally.

Parameters:
- MEM_TIMEOUT, default 0: max cycles spent waiting on mem_ready in any memory state. 0 disables the watchdog. Range 0..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from the datapath
- mem_ready  in  1  memory completes the current access this cycle
- ALU_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- ALUsrcA  out  1  0 = PC, 1 = regA
- ALUsrcB  out  2  00 regB, 01 const 4, 10 SignImm, 11 SignImm<<2
- PCsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- PCen  out  1  PC register load enable
- IRwrite  out  1  instruction register load enable
- MEMwrite  out  1  memory write strobe
- REGwrite  out  1  register file write enable
- REGdist  out  1  1 = rd, 0 = rt
- MEMtoREG  out  1  1 = memory data, 0 = ALUOut
- instr_done  out  1  one-cycle pulse when the last state of an instruction completes
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Outputs are decoded combinationally from the state, plus zero/mem_ready where noted. Unlisted enables are 0 and unlisted selects are 0.
- FETCH:
  - Drive IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=00, PCsrc=00.
  - IRwrite = PCen = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE:
  - Drive ALUsrcA=0, ALUsrcB=11, ALUop=00 (branch target precomputed into ALUOut).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: illegal_op=1, instr_done=1, next FETCH.
- MEMADR: ALUsrcA=1, ALUsrcB=10, ALUop=00; lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD=1; hold until mem_ready, then -> MEMWB.
- MEMWB: REGwrite=1, REGdist=0, MEMtoREG=1, instr_done=1; -> FETCH.
- MEMWR:
  - IorD=1, MEMwrite=1, held for every wait cycle.
  - On mem_ready: instr_done=1, -> FETCH.
- EXECUTE: ALUsrcA=1, ALUsrcB=00, ALUop=10; -> ALUWB.
- ALUWB: REGwrite=1, REGdist=1, MEMtoREG=0, instr_done=1; -> FETCH.
- BRANCH:
  - ALUsrcA=1, ALUsrcB=00, ALUop=01, PCsrc=01.
  - PCen = zero; instr_done=1; -> FETCH.
- ADDIEX: ALUsrcA=1, ALUsrcB=10, ALUop=00; -> ADDIWB.
- ADDIWB: REGwrite=1, REGdist=0, MEMtoREG=0, instr_done=1; -> FETCH.
- JUMP: PCsrc=10, PCen=1, instr_done=1; -> FETCH.
- ALU decode:
  - ALUop 00 -> 010; ALUop 01 -> 110.
  - ALUop 10 by func: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; unknown func -> 010.
- Latency with mem_ready held at 1: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5 cycles. Each memory state adds one cycle per mem_ready=0 cycle.
- Watchdog:
  - 8-bit wait counter; cleared on state change and on reset; increments while in FETCH/MEMRD/MEMWR with mem_ready=0.
  - When MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT:
    - mem_timeout=1 and next state FETCH; PCen, IRwrite and MEMwrite forced 0 that cycle.
    - instr_done=0.
- Reset:
  - reset=1 at any edge sets state to FETCH and clears the counter.
  - While reset is high, all enables (PCen, IRwrite, MEMwrite, REGwrite) and all pulses are forced 0.
  - Reset in any state, including mid-wait, abandons the instruction with no writes.
  - The first cycle after reset is a normal FETCH.
- Illegal state encodings -> FETCH.

Optional Feature:
- Macro BNE_EN.
- Defined: opcode 000101 decodes to BRANCH with an internal bne flag captured in DECODE; in BRANCH, PCen = ~zero.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH).

Test Plan:
- add, opcode 000000 func 100000, mem_ready=1 → FETCH, DECODE, EXECUTE, ALUWB. ALU_control=010 in EXECUTE; REGwrite=1 and REGdist=1 in ALUWB; instr_done pulses in cycle 4.
- lw (100011), mem_ready low 2 cycles in MEMRD → 7 total cycles. IorD=1 throughout MEMRD; MEMWB has REGwrite=1, MEMtoREG=1.
- beq (000100) with zero=1, then zero=0 → PCen=1, PCsrc=01 in BRANCH for the first; PCen=0 for the second; ALU_control=110 in both.
- Opcode 111111 → illegal_op=1 in DECODE, no REGwrite/MEMwrite, FETCH next cycle. With BNE_EN: opcode 000101 and zero=0 → PCen=1.
- MEM_TIMEOUT=3, sw with mem_ready stuck at 0 → MEMwrite high 3 cycles, then mem_timeout pulse; FETCH next with MEMwrite=0.
- reset asserted in MEMWR → next edge in FETCH with all enables 0 during reset. With mem_ready=1 after release, IRwrite=1 in the first cycle after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing the multicycle MIPS datapath
//
// Purpose: Moore-style controller. One state per datapath step of lw, sw,
// R-type, beq, addi and j; outputs are decoded from the current state, with
// zero and mem_ready folded in where an access or branch resolves. A wait
// counter watches the memory states and aborts back to FETCH after
// MEM_TIMEOUT stalled cycles (0 turns the watchdog off).
//
// Optional feature: define BNE_EN to decode opcode 000101 (bne) as a branch
// taken on ~zero. Without it, 000101 is reported through illegal_op.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode, func          IR[31:26], IR[5:0]
//   zero                  ALU zero flag
//   mem_ready             memory finishes the current access this cycle
//   ALU_control           010 add, 110 sub, 000 and, 001 or, 111 slt
//   IorD, ALUsrcA,
//   ALUsrcB, PCsrc        datapath mux selects
//   PCen, IRwrite,
//   MEMwrite, REGwrite    write/load enables
//   REGdist, MEMtoREG     register file destination / write-data selects
//   instr_done            pulse on the last cycle of an instruction
//   illegal_op            pulse in DECODE on an unsupported opcode
//   mem_timeout           pulse when the memory watchdog fires
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALU_control,
  output logic       IorD,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] PCsrc,
  output logic       PCen,
  output logic       IRwrite,
  output logic       MEMwrite,
  output logic       REGwrite,
  output logic       REGdist,
  output logic       MEMtoREG,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] alu_op;
  logic       mem_wait;
  logic       timeout_hit;
  logic       branch_taken;

`ifdef BNE_EN
  logic bne_q, bne_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= 8'd0;
`ifdef BNE_EN
      bne_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef BNE_EN
      bne_q      <= bne_d;
`endif
    end
  end

  // States that can stall on the memory handshake.
  assign mem_wait    = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout_hit = (TO_LIMIT != 8'd0) && mem_wait && (wait_cnt_q == TO_LIMIT);

`ifdef BNE_EN
  assign branch_taken = bne_q ? ~zero : zero;
`else
  assign branch_taken = zero;
`endif

  always_comb begin
    state_d     = state_q;
    alu_op      = 2'b00;
    IorD        = 1'b0;
    ALUsrcA     = 1'b0;
    ALUsrcB     = 2'b00;
    PCsrc       = 2'b00;
    PCen        = 1'b0;
    IRwrite     = 1'b0;
    MEMwrite    = 1'b0;
    REGwrite    = 1'b0;
    REGdist     = 1'b0;
    MEMtoREG    = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
`ifdef BNE_EN
    bne_d       = bne_q;
`endif

    case (state_q)
      FETCH: begin
        ALUsrcB = 2'b01;
        IRwrite = mem_ready;
        PCen    = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Branch target is computed here so BRANCH can load it from ALUOut.
        ALUsrcB = 2'b11;
`ifdef BNE_EN
        bne_d   = (opcode == 6'b000101);
`endif
        case (opcode)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXECUTE;
          6'b000100:            state_d = BRANCH;
`ifdef BNE_EN
          6'b000101:            state_d = BRANCH;
`endif
          6'b001000:            state_d = ADDIEX;
          6'b000010:            state_d = JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        // The IR still holds the opcode, so lw/sw is re-read rather than stored.
        state_d = (opcode == 6'b101011) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        REGwrite   = 1'b1;
        MEMtoREG   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MEMwrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      EXECUTE: begin
        ALUsrcA = 1'b1;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        REGwrite   = 1'b1;
        REGdist    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        ALUsrcA    = 1'b1;
        alu_op     = 2'b01;
        PCsrc      = 2'b01;
        PCen       = branch_taken;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        REGwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        PCsrc      = 2'b10;
        PCen       = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Watchdog abort: drop the access without committing anything.
    if (timeout_hit) begin
      mem_timeout = 1'b1;
      PCen        = 1'b0;
      IRwrite     = 1'b0;
      MEMwrite    = 1'b0;
      instr_done  = 1'b0;
      state_d     = FETCH;
    end

    // Counter restarts on any state change and on a watchdog abort (which
    // may leave FETCH in FETCH); otherwise it counts stalled cycles.
    if ((state_d != state_q) || timeout_hit) begin
      wait_cnt_d = 8'd0;
    end else if (mem_wait && !mem_ready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    // Reset suppresses every side effect; selects keep decoding harmlessly.
    if (reset) begin
      PCen        = 1'b0;
      IRwrite     = 1'b0;
      MEMwrite    = 1'b0;
      REGwrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  // ALUop / func to ALU_control, shared with the single-cycle controller.
  always_comb begin
    ALU_control = 3'b010;
    case (alu_op)
      2'b00: ALU_control = 3'b010;
      2'b01: ALU_control = 3'b110;
      default: begin
        case (func)
          6'b100000: ALU_control = 3'b010;
          6'b100010: ALU_control = 3'b110;
          6'b100100: ALU_control = 3'b000;
          6'b100101: ALU_control = 3'b001;
          6'b101010: ALU_control = 3'b111;
          default:   ALU_control = 3'b010;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int TB_TO = 3;
  localparam int K_ILL = 0, K_LW = 1, K_SW = 2, K_R = 3, K_BEQ = 4, K_BNE = 5, K_ADDI = 6, K_J = 7;

  typedef struct packed {
    logic [2:0] alu;
    logic       iord;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       irw;
    logic       memw;
    logic       regw;
    logic       regd;
    logic       m2r;
    logic       done;
    logic       ill;
    logic       tmo;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, zr, mr;
  logic [5:0] op, fn;
  logic [2:0] ALU_control;
  logic       IorD, ALUsrcA, PCen, IRwrite, MEMwrite, REGwrite, REGdist, MEMtoREG;
  logic [1:0] ALUsrcB, PCsrc;
  logic       instr_done, illegal_op, mem_timeout;

  multicycle_controller #(.MEM_TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(rst), .opcode(op), .func(fn), .zero(zr), .mem_ready(mr),
    .ALU_control(ALU_control), .IorD(IorD), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .PCsrc(PCsrc), .PCen(PCen), .IRwrite(IRwrite), .MEMwrite(MEMwrite),
    .REGwrite(REGwrite), .REGdist(REGdist), .MEMtoREG(MEMtoREG),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  outs_t dut_o;
  assign dut_o = {ALU_control, IorD, ALUsrcA, ALUsrcB, PCsrc, PCen, IRwrite, MEMwrite,
                  REGwrite, REGdist, MEMtoREG, instr_done, illegal_op, mem_timeout};

  int    comps = 0;
  int    errs  = 0;
  // Reference model: position within the current instruction (0 = fetch,
  // 1 = decode, 2.. = later steps), instruction kind and stall count.
  int    m_ph   = 0;
  int    m_kind = K_ILL;
  int    m_cnt  = 0;
  outs_t obs, expv;

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b000100: return K_BEQ;
`ifdef BNE_EN
      6'b000101: return K_BNE;
`endif
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic in_mem_step();
    return (m_ph == 0) || (m_ph == 3 && (m_kind == K_LW || m_kind == K_SW));
  endfunction

  function automatic outs_t model_out(input logic r, input logic [5:0] o, input logic [5:0] f,
                                      input logic z, input logic m);
    outs_t e;
    e = '0;
    e.alu = 3'b010;
    case (m_ph)
      0: begin e.srcb = 2'b01; e.irw = m; e.pcen = m; end
      1: begin
        e.srcb = 2'b11;
        if (classify(o) == K_ILL) begin e.ill = 1'b1; e.done = 1'b1; end
      end
      2: begin
        if (m_kind == K_LW || m_kind == K_SW || m_kind == K_ADDI) begin
          e.srca = 1'b1; e.srcb = 2'b10;
        end else if (m_kind == K_R) begin
          e.srca = 1'b1; e.alu = alu_of(f);
        end else if (m_kind == K_BEQ || m_kind == K_BNE) begin
          e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.done = 1'b1;
          e.pcen = (m_kind == K_BEQ) ? z : ~z;
        end else if (m_kind == K_J) begin
          e.pcsrc = 2'b10; e.pcen = 1'b1; e.done = 1'b1;
        end
      end
      3: begin
        if (m_kind == K_LW) e.iord = 1'b1;
        else if (m_kind == K_SW) begin e.iord = 1'b1; e.memw = 1'b1; e.done = m; end
        else if (m_kind == K_R) begin e.regw = 1'b1; e.regd = 1'b1; e.done = 1'b1; end
        else if (m_kind == K_ADDI) begin e.regw = 1'b1; e.done = 1'b1; end
      end
      4: begin e.regw = 1'b1; e.m2r = 1'b1; e.done = 1'b1; end
      default: ;
    endcase
    if (in_mem_step() && m_cnt == TB_TO) begin
      e.tmo = 1'b1; e.pcen = 1'b0; e.irw = 1'b0; e.memw = 1'b0; e.done = 1'b0;
    end
    if (r) begin
      e.pcen = 1'b0; e.irw = 1'b0; e.memw = 1'b0; e.regw = 1'b0;
      e.done = 1'b0; e.ill = 1'b0; e.tmo = 1'b0;
    end
    return e;
  endfunction

  function automatic void model_adv(input logic r, input logic [5:0] o, input logic m, input outs_t e);
    if (r || e.tmo || e.done) begin
      m_ph  = 0;
      m_cnt = 0;
    end else if (in_mem_step() && !m) begin
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else begin
      if (m_ph == 1) m_kind = classify(o);
      m_ph  = m_ph + 1;
      m_cnt = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    comps++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic m);
    rst = r; op = o; fn = f; zr = z; mr = m;
    @(negedge clk);
    expv = model_out(r, o, f, z, m);
    obs  = dut_o;
    chk("cycle_outputs", 32'(obs), 32'(expv));
    @(posedge clk);
    model_adv(r, o, m, expv);
    #1;
  endtask

  // Runs one instruction from FETCH, inserting `waits` stalls in the data
  // access step, and checks the cycle count up to instr_done.
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int waits, input int exp_len, input string tag);
    int n, waited;
    logic m, seen;
    n = 0; waited = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      m = 1'b1;
      if (m_ph == 3 && (m_kind == K_LW || m_kind == K_SW) && waited < waits) begin
        m = 1'b0;
        waited++;
      end
      step(1'b0, o, f, z, m);
      n++;
      if (obs.done) seen = 1'b1;
    end
    chk(tag, 32'(n), 32'(exp_len));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] rop, rfn;

    // Reset holds enables low even with mem_ready high.
    step(1'b1, 6'd0, 6'd0, 1'b0, 1'b1);
    step(1'b1, 6'd0, 6'd0, 1'b0, 1'b1);
    chk("reset_irwrite", 32'(obs.irw), 32'(1'b0));
    chk("reset_pcen", 32'(obs.pcen), 32'(1'b0));

    // add: FETCH, DECODE, EXECUTE, ALUWB
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    chk("add_fetch_irwrite", 32'(obs.irw), 32'(1'b1));
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    chk("add_exec_alu", 32'(obs.alu), 32'(3'b010));
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 1'b1);
    chk("add_wb_regwrite", 32'(obs.regw), 32'(1'b1));
    chk("add_wb_regdist", 32'(obs.regd), 32'(1'b1));
    chk("add_wb_done", 32'(obs.done), 32'(1'b1));

    // Latencies, including lw with two stalls in MEMRD.
    step(1'b1, 6'd0, 6'd0, 1'b0, 1'b1);
    do_instr(6'b100011, 6'd0, 1'b0, 2, 7, "lat_lw_2wait");
    do_instr(6'b100011, 6'd0, 1'b0, 0, 5, "lat_lw");
    do_instr(6'b101011, 6'd0, 1'b0, 0, 4, "lat_sw");
    do_instr(6'b000000, 6'b101010, 1'b0, 0, 4, "lat_rtype");
    do_instr(6'b001000, 6'd0, 1'b0, 0, 4, "lat_addi");
    do_instr(6'b000100, 6'd0, 1'b1, 0, 3, "lat_beq");
    do_instr(6'b000010, 6'd0, 1'b0, 0, 3, "lat_j");

    // beq taken then not taken.
    for (int t = 0; t < 2; t++) begin
      logic zz;
      zz = (t == 0);
      step(1'b0, 6'b000100, 6'd0, zz, 1'b1);
      step(1'b0, 6'b000100, 6'd0, zz, 1'b1);
      step(1'b0, 6'b000100, 6'd0, zz, 1'b1);
      chk("beq_pcen", 32'(obs.pcen), 32'(zz));
      chk("beq_pcsrc", 32'(obs.pcsrc), 32'(2'b01));
      chk("beq_alu", 32'(obs.alu), 32'(3'b110));
    end

    // Illegal opcode.
    step(1'b0, 6'b111111, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b111111, 6'd0, 1'b0, 1'b1);
    chk("ill_pulse", 32'(obs.ill), 32'(1'b1));
    chk("ill_no_regwrite", 32'(obs.regw), 32'(1'b0));
    chk("ill_no_memwrite", 32'(obs.memw), 32'(1'b0));
    step(1'b0, 6'b111111, 6'd0, 1'b0, 1'b1);
    chk("ill_back_to_fetch", 32'(obs.irw), 32'(1'b1));
    step(1'b1, 6'd0, 6'd0, 1'b0, 1'b1);

    // bne (000101) with zero=0.
    step(1'b0, 6'b000101, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b000101, 6'd0, 1'b0, 1'b1);
`ifdef BNE_EN
    chk("bne_decode_legal", 32'(obs.ill), 32'(1'b0));
    step(1'b0, 6'b000101, 6'd0, 1'b0, 1'b1);
    chk("bne_pcen", 32'(obs.pcen), 32'(1'b1));
`else
    chk("bne_illegal", 32'(obs.ill), 32'(1'b1));
`endif
    step(1'b1, 6'd0, 6'd0, 1'b0, 1'b1);

    // sw with mem_ready stuck low: three write cycles, then the watchdog.
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
      chk("to_memwrite_held", 32'(obs.memw), 32'(1'b1));
      chk("to_not_yet", 32'(obs.tmo), 32'(1'b0));
    end
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
    chk("to_pulse", 32'(obs.tmo), 32'(1'b1));
    chk("to_memwrite_off", 32'(obs.memw), 32'(1'b0));
    chk("to_no_done", 32'(obs.done), 32'(1'b0));
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
    chk("to_fetch_srcb", 32'(obs.srcb), 32'(2'b01));
    chk("to_fetch_memwrite", 32'(obs.memw), 32'(1'b0));

    // Reset while stalled in MEMWR.
    step(1'b1, 6'd0, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b0);
    chk("rst_pre_memwrite", 32'(obs.memw), 32'(1'b1));
    step(1'b1, 6'b101011, 6'd0, 1'b0, 1'b0);
    chk("rst_memwrite_off", 32'(obs.memw), 32'(1'b0));
    step(1'b1, 6'b101011, 6'd0, 1'b0, 1'b1);
    chk("rst_fetch_irwrite_off", 32'(obs.irw), 32'(1'b0));
    chk("rst_fetch_srcb", 32'(obs.srcb), 32'(2'b01));
    step(1'b0, 6'b101011, 6'd0, 1'b0, 1'b1);
    chk("rst_release_irwrite", 32'(obs.irw), 32'(1'b1));

    // Randomized traffic against the model.
    rop = 6'd0; rfn = 6'd0;
    for (int c = 0; c < 3000; c++) begin
      if (m_ph == 0) begin
        case ($urandom_range(0, 7))
          0: rop = 6'b100011;
          1: rop = 6'b101011;
          2: rop = 6'b000000;
          3: rop = 6'b000100;
          4: rop = 6'b001000;
          5: rop = 6'b000010;
          6: rop = 6'b000101;
          default: rop = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0: rfn = 6'b100000;
          1: rfn = 6'b100010;
          2: rfn = 6'b100100;
          3: rfn = 6'b100101;
          4: rfn = 6'b101010;
          default: rfn = 6'($urandom);
        endcase
      end
      step(1'($urandom_range(0, 59) == 0), rop, rfn, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
